id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus EX-stage operand select that feeds test_ALU (a, b, in, Shamt).
//  - Latches the decoded instruction each cycle.
//  - Forwards results from EX/MEM and MEM/WB.
//  - Sign/zero-extends the immediate.
//  - Detects load-use hazards and inserts bubbles.
//  - Honours the global stall and flush.

---
 rtl/id_ex_operand_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand selection for the ALU.
// Covers load-use bubble insertion, EX/MEM and MEM/WB forwarding, and immediate extension.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              id_zero_ext,
    input  logic [4:0]        id_shamt,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              hazard_stall,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] ext_imm;
        logic [4:0]        shamt;
        logic [CTRL_W-1:0] ctrl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_reg_t;

    ex_reg_t           ex_q;
    ex_reg_t           ex_d;
    logic [DATA_W-1:0] id_ext_imm;
    logic              exm_hit_rs;
    logic              exm_hit_rt;
    logic              wb_hit_rs;
    logic              wb_hit_rt;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    assign id_ext_imm = id_zero_ext ? {{(DATA_W-16){1'b0}}, id_imm}
                                    : {{(DATA_W-16){id_imm[15]}}, id_imm};

    // A load in EX cannot supply its data until WB, so a dependent ID instruction must wait.
    assign hazard_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                          ((ex_q.rd == id_rs) ||
                           ((ex_q.rd == id_rt) && (!id_alu_src || id_mem_write)));

    always_comb begin
        // NOTE: default to hold so every path assigns ex_d and no latch is inferred.
        ex_d = ex_q;
        if (flush_in) begin
            ex_d = '0;
        end else if (stall_in) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid      = id_valid;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = id_rd;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.ext_imm    = id_ext_imm;
            ex_d.shamt      = id_shamt;
            ex_d.ctrl       = id_alu_ctrl;
            ex_d.alu_src    = id_alu_src;
            ex_d.reg_write  = id_reg_write  & id_valid;
            ex_d.mem_read   = id_mem_read   & id_valid;
            ex_d.mem_write  = id_mem_write  & id_valid;
            ex_d.mem_to_reg = id_mem_to_reg & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of order.
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    assign exm_hit_rs = exm_reg_write && (exm_rd != '0) && (exm_rd == ex_q.rs);
    assign exm_hit_rt = exm_reg_write && (exm_rd != '0) && (exm_rd == ex_q.rt);
    assign wb_hit_rs  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_q.rs);
    assign wb_hit_rt  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_q.rt);

    assign fwd_rs = exm_hit_rs ? exm_result : (wb_hit_rs ? wb_result : ex_q.rs_data);
    assign fwd_rt = exm_hit_rt ? exm_result : (wb_hit_rt ? wb_result : ex_q.rt_data);

    assign alu_a         = fwd_rs;
    assign alu_b         = ex_q.alu_src ? ex_q.ext_imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_shamt     = ex_q.shamt;
    assign alu_ctrl      = ex_q.ctrl;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table for capture/forwarding,
// hand-written sequences for reset, load-use, stall and flush.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush_in, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        id_zero_ext;
    logic [4:0]  id_shamt;
    logic [15:0] id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        hazard_stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt;
    logic [15:0] alu_ctrl;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_zero_ext(id_zero_ext), .id_shamt(id_shamt), .id_alu_ctrl(id_alu_ctrl),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .hazard_stall(hazard_stall), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data;
        logic [15:0] imm;
        logic        zext;
        logic [4:0]  shamt;
        logic [15:0] ctrl;
        logic        alu_src, valid, rw, mr, mw, m2r;
        logic        exm_w;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        wb_w;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic [31:0] e_a, e_b, e_store;
        logic        e_valid;
        logic [3:0]  e_ctrls;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ex(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] st, input logic v, input logic [3:0] c,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] ctl,
                            input logic hz);
        check({tag, ".alu_a"}, alu_a, a);
        check({tag, ".alu_b"}, alu_b, b);
        check({tag, ".store"}, ex_store_data, st);
        check({tag, ".valid"}, 32'(ex_valid), 32'(v));
        check({tag, ".ctrls"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'(c));
        check({tag, ".rd"}, 32'(ex_rd), 32'(rd));
        check({tag, ".shamt"}, 32'(alu_shamt), 32'(sh));
        check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(ctl));
        check({tag, ".hazard"}, 32'(hazard_stall), 32'(hz));
    endtask

    task automatic drive(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
        id_rs_data = v.rs_data; id_rt_data = v.rt_data;
        id_imm = v.imm; id_zero_ext = v.zext; id_shamt = v.shamt; id_alu_ctrl = v.ctrl;
        id_alu_src = v.alu_src; id_valid = v.valid;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; id_mem_to_reg = v.m2r;
        exm_reg_write = v.exm_w; exm_rd = v.exm_rd; exm_result = v.exm_res;
        wb_reg_write = v.wb_w; wb_rd = v.wb_rd; wb_result = v.wb_res;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;

        // v0: sign-extended immediate on B, rs straight from regfile
        v = '0; v.rs = 3; v.rs_data = 32'd5; v.rt = 2; v.rt_data = 32'd9; v.rd = 10;
        v.imm = 16'h8000; v.alu_src = 1; v.shamt = 4; v.ctrl = 16'h0012; v.valid = 1; v.rw = 1;
        v.e_a = 32'd5; v.e_b = 32'hFFFF8000; v.e_store = 32'd9; v.e_valid = 1; v.e_ctrls = 4'b1000;
        vecs[0] = v;
        // v1: same, zero-extended
        v.zext = 1; v.e_b = 32'h00008000;
        vecs[1] = v;
        // v2: both stages write rs=4; EX/MEM wins. rt from regfile.
        v = '0; v.rs = 4; v.rs_data = 32'd1; v.rt = 5; v.rt_data = 32'h77; v.rd = 11;
        v.ctrl = 16'h0003; v.shamt = 31; v.valid = 1; v.rw = 1;
        v.exm_w = 1; v.exm_rd = 4; v.exm_res = 32'hAA; v.wb_w = 1; v.wb_rd = 4; v.wb_res = 32'hBB;
        v.e_a = 32'hAA; v.e_b = 32'h77; v.e_store = 32'h77; v.e_valid = 1; v.e_ctrls = 4'b1000;
        vecs[2] = v;
        // v3: EX/MEM stops writing -> MEM/WB value
        v.exm_w = 0; v.e_a = 32'hBB;
        vecs[3] = v;
        // v4: register 0 never forwards
        v = '0; v.rd = 1; v.valid = 1; v.rw = 1;
        v.exm_w = 1; v.exm_rd = 0; v.exm_res = 32'hCC; v.wb_w = 1; v.wb_rd = 0; v.wb_res = 32'hDD;
        v.e_valid = 1; v.e_ctrls = 4'b1000;
        vecs[4] = v;
        // v5: invalid ID -> controls masked, data still captured and forwarded
        v = '0; v.rs = 6; v.rs_data = 32'h1234; v.rt = 6; v.rt_data = 32'h5678; v.rd = 6;
        v.ctrl = 16'hA5A5; v.valid = 0; v.rw = 1; v.mr = 1; v.mw = 1; v.m2r = 1;
        v.exm_w = 1; v.exm_rd = 6; v.exm_res = 32'h55; v.wb_w = 1; v.wb_rd = 6; v.wb_res = 32'h66;
        v.e_a = 32'h55; v.e_b = 32'h55; v.e_store = 32'h55; v.e_valid = 0; v.e_ctrls = 4'b0000;
        vecs[5] = v;
        // v6: rt forwarded from MEM/WB only, store
        v = '0; v.rs = 1; v.rs_data = 32'h10; v.rt = 2; v.rt_data = 32'h20; v.rd = 0;
        v.ctrl = 16'h0100; v.valid = 1; v.mw = 1;
        v.exm_w = 1; v.exm_rd = 3; v.exm_res = 32'h33; v.wb_w = 1; v.wb_rd = 2; v.wb_res = 32'h99;
        v.e_a = 32'h10; v.e_b = 32'h99; v.e_store = 32'h99; v.e_valid = 1; v.e_ctrls = 4'b0010;
        vecs[6] = v;
        // v7: load, positive immediate, store data still forwarded
        v.imm = 16'h7FFF; v.alu_src = 1; v.mw = 0; v.rw = 1; v.mr = 1; v.m2r = 1; v.rd = 5;
        v.e_b = 32'h00007FFF; v.e_ctrls = 4'b1101;
        vecs[7] = v;
        // v8: independent of the load in EX, no forwarding
        v = '0; v.rs = 8; v.rs_data = 32'hDEADBEEF; v.rt = 9; v.rt_data = 32'h1; v.rd = 13;
        v.ctrl = 16'hFFFF; v.shamt = 17; v.valid = 1; v.rw = 1;
        v.e_a = 32'hDEADBEEF; v.e_b = 32'h1; v.e_store = 32'h1; v.e_valid = 1; v.e_ctrls = 4'b1000;
        vecs[8] = v;

        // Reset with junk on ID, then reset held during stall
        v = vecs[0]; v.mr = 1; v.mw = 1; v.m2r = 1;
        drive(v);
        exm_reg_write = 0; wb_reg_write = 0;
        rst = 1; stall_in = 0; flush_in = 0;
        step();
        check_ex("reset", 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
        stall_in = 1;
        step();
        check_ex("reset_stall", 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
        rst = 0; stall_in = 0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            step();
            check_ex($sformatf("v%0d", i), vecs[i].e_a, vecs[i].e_b, vecs[i].e_store,
                     vecs[i].e_valid, vecs[i].e_ctrls, vecs[i].rd, vecs[i].shamt,
                     vecs[i].ctrl, 1'b0);
        end

        // Load-use: lw r7 <- [r1+4] enters EX
        v = '0; v.rs = 1; v.rs_data = 32'h100; v.rt = 7; v.rd = 7; v.imm = 16'd4;
        v.alu_src = 1; v.ctrl = 16'h0020; v.valid = 1; v.rw = 1; v.mr = 1; v.m2r = 1;
        drive(v);
        step();
        check("lw.mem_read", 32'(ex_mem_read), 32'd1);
        check("lw.alu_b", alu_b, 32'd4);
        check("lw.self_no_hazard", 32'(hazard_stall), 32'd0);
        id_rs = 2; id_rt = 7; id_alu_src = 1; id_mem_write = 0; id_mem_read = 0;
        #1 check("hz.rt_imm", 32'(hazard_stall), 32'd0);
        id_mem_write = 1;
        #1 check("hz.rt_store", 32'(hazard_stall), 32'd1);
        id_mem_write = 0; id_alu_src = 0;
        #1 check("hz.rt_reg", 32'(hazard_stall), 32'd1);
        id_valid = 0;
        #1 check("hz.id_invalid", 32'(hazard_stall), 32'd0);
        // add r8 <- r7 + r3
        v = '0; v.rs = 7; v.rt = 3; v.rt_data = 32'h3; v.rd = 8; v.ctrl = 16'h0021;
        v.valid = 1; v.rw = 1;
        drive(v);
        #1 check("hz.rs", 32'(hazard_stall), 32'd1);
        stall_in = 1;
        step();
        check_ex("hz.global_stall", 32'h100, 32'd4, 0, 1, 4'b1101, 5'd7, 0, 16'h0020, 1);
        stall_in = 0;
        step();
        check_ex("hz.bubble", 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
        wb_reg_write = 1; wb_rd = 7; wb_result = 32'hCAFEF00D;
        step();
        check_ex("hz.wb_fwd", 32'hCAFEF00D, 32'h3, 32'h3, 1, 4'b1000, 5'd8, 0, 16'h0021, 0);

        // Global stall holds EX while ID changes, then flush under stall bubbles
        v = '0; v.rs = 10; v.rs_data = 32'h1111; v.rt = 11; v.rt_data = 32'h2222; v.rd = 12;
        v.shamt = 9; v.ctrl = 16'hBEEF; v.valid = 1; v.rw = 1;
        drive(v);
        step();
        check("st.load_a", alu_a, 32'h1111);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs_data = 32'(i); id_rt_data = 32'(i + 100); id_rd = 5'(i); id_alu_ctrl = 16'(i);
            id_shamt = 5'(i); id_valid = 1'(i & 1); id_alu_src = 1; id_imm = 16'(i);
            step();
            check_ex($sformatf("stall%0d", i), 32'h1111, 32'h2222, 32'h2222, 1, 4'b1000,
                     5'd12, 5'd9, 16'hBEEF, 0);
        end
        flush_in = 1;
        step();
        check_ex("flush_stall", 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
        flush_in = 0; stall_in = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
